// File: rtl/dma_pkg.sv
// Shared types and default sizing for the DMA data-move engine.
package dma_pkg;

    localparam int DMA_CH_DEF = 8;
    localparam int AW_DEF     = 32;
    localparam int DW_DEF     = 32;
    localparam int LEN_W_DEF  = 16;
    localparam int CH_IDX_W   = $clog2(DMA_CH_DEF);
    localparam int BEAT_BYTES = DW_DEF / 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        DONE,
        RELEASE
    } xfer_state_e;

endpackage

// File: rtl/dma_onehot_enc.sv
// Lowest-set-bit encoder for the arbiter grant; multi-hot resolves to the lowest index.
module dma_onehot_enc
    import dma_pkg::*;
#(
    parameter int DMA_CH = DMA_CH_DEF,
    parameter int IDX_W  = CH_IDX_W
) (
    input  logic [DMA_CH-1:0] vec_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic              any_o
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = DMA_CH - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign any_o = |vec_i;

endmodule

// File: rtl/dma_xfer_engine.sv
// Single-transfer DMA engine: latches the granted channel's descriptor and moves it
// beat by beat (read, then write) over req/gnt memory ports.
module dma_xfer_engine
    import dma_pkg::*;
#(
    parameter int DMA_CH = DMA_CH_DEF,
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [DMA_CH-1:0]         grant_i,
    input  logic [DMA_CH*AW-1:0]      ch_src_addr_i,
    input  logic [DMA_CH*AW-1:0]      ch_dst_addr_i,
    input  logic [DMA_CH*LEN_W-1:0]   ch_len_i,
    output logic                      rd_req_o,
    output logic [AW-1:0]             rd_addr_o,
    input  logic                      rd_gnt_i,
    input  logic                      rd_vld_i,
    input  logic [DW-1:0]             rd_data_i,
    output logic                      wr_req_o,
    output logic [AW-1:0]             wr_addr_o,
    output logic [DW-1:0]             wr_data_o,
    input  logic                      wr_gnt_i,
    output logic                      busy_o,
    output logic [$clog2(DMA_CH)-1:0] active_ch_o,
    output logic [DMA_CH-1:0]         ch_done_o,
    output logic [DMA_CH-1:0]         ch_abort_o
);

    localparam int            IDX_W = $clog2(DMA_CH);
    localparam logic [AW-1:0] STEP  = AW'(DW / 8);

    xfer_state_e state, nxt;

    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  enc_idx;
    logic              any_grant;
    logic [AW-1:0]     src;
    logic [AW-1:0]     dst;
    logic [LEN_W-1:0]  rem;
    logic [DW-1:0]     hold;
    logic              abort;

    logic [AW-1:0]     src_sel;
    logic [AW-1:0]     dst_sel;
    logic [LEN_W-1:0]  len_sel;
    logic              granted;
    logic              abort_now;
    logic [DMA_CH-1:0] idx_mask;

    dma_onehot_enc #(
        .DMA_CH (DMA_CH),
        .IDX_W  (IDX_W)
    ) u_enc (
        .vec_i (grant_i),
        .idx_o (enc_idx),
        .any_o (any_grant)
    );

    assign src_sel   = ch_src_addr_i[int'(idx) * AW +: AW];
    assign dst_sel   = ch_dst_addr_i[int'(idx) * AW +: AW];
    assign len_sel   = ch_len_i[int'(idx) * LEN_W +: LEN_W];
    assign granted   = grant_i[idx];
    // A grant lost on the same cycle as the final write handshake still counts as an abort.
    assign abort_now = abort | ~granted;
    assign idx_mask  = DMA_CH'(1) << idx;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            idx   <= '0;
            src   <= '0;
            dst   <= '0;
            rem   <= '0;
            hold  <= '0;
            abort <= 1'b0;
        end else begin
            state <= nxt;
            case (state)
                IDLE: begin
                    abort <= 1'b0;
                    if (any_grant) begin
                        idx <= enc_idx;
                    end
                end
                LOAD: begin
                    src <= src_sel;
                    dst <= dst_sel;
                    rem <= len_sel;
                end
                RD_REQ: begin
                    if (!granted) abort <= 1'b1;
                end
                RD_WAIT: begin
                    if (!granted) abort <= 1'b1;
                    if (rd_vld_i) hold <= rd_data_i;
                end
                WR_REQ: begin
                    if (!granted) abort <= 1'b1;
                    if (wr_gnt_i) begin
                        src <= src + STEP;
                        dst <= dst + STEP;
                        rem <= rem - LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nxt         = state;
        rd_req_o    = 1'b0;
        rd_addr_o   = '0;
        wr_req_o    = 1'b0;
        wr_addr_o   = '0;
        wr_data_o   = '0;
        busy_o      = (state != IDLE);
        active_ch_o = '0;
        ch_done_o   = '0;
        ch_abort_o  = '0;
        if (state != IDLE) begin
            active_ch_o = idx;
        end

        case (state)
            IDLE: begin
                if (any_grant) nxt = LOAD;
            end
            LOAD: begin
                nxt = (len_sel == '0) ? DONE : RD_REQ;
            end
            RD_REQ: begin
                rd_req_o  = 1'b1;
                rd_addr_o = src;
                if (rd_gnt_i) nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (rd_vld_i) nxt = WR_REQ;
            end
            WR_REQ: begin
                wr_req_o  = 1'b1;
                wr_addr_o = dst;
                wr_data_o = hold;
                if (wr_gnt_i) begin
                    nxt = ((rem == LEN_W'(1)) || abort_now) ? DONE : RD_REQ;
                end
            end
            DONE: begin
                ch_done_o = idx_mask;
                if (abort) ch_abort_o = idx_mask;
                nxt = RELEASE;
            end
            RELEASE: begin
                // Hold off until the arbiter's stale grant for this channel has cleared.
                if (!granted) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

endmodule
